// File: rtl/core_mem_access_pkg.sv
// Shared definitions for the memory stage: load/store width codes, trap causes, FSM states.
package core_mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        CAUSE_LOAD_MISALIGN  = 2'd0,
        CAUSE_STORE_MISALIGN = 2'd1,
        CAUSE_BUS_TIMEOUT    = 2'd2
    } trap_cause_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

endpackage

// File: rtl/core_mem_access_if.sv
// Data bus between the memory stage (master) and memory (slave).
// Handshake: master raises req with we/addr/sel/wdata and holds them all stable until the
// slave returns ack for exactly one cycle; rdata is only meaningful in that ack cycle.
interface core_mem_access_if;
    logic        req;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/core_mem_access_lsu_store_align.sv
// Combinational lane alignment: byte enables, replicated store data and misalignment detection.
module core_mem_access_lsu_store_align
    import core_mem_access_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic        misaligned
);

    always_comb begin
        sel        = 4'b0000;
        wdata      = data;
        misaligned = 1'b0;
        if (is_load) begin
            // Loads always fetch the whole word; the write stage picks the lanes.
            case (funct3)
                F3_LB, F3_LBU: sel = 4'b1111;
                F3_LH, F3_LHU: begin
                    sel        = 4'b1111;
                    misaligned = addr_lo[0];
                end
                F3_LW: begin
                    sel        = 4'b1111;
                    misaligned = (addr_lo != 2'b00);
                end
                default: sel = 4'b0000;
            endcase
        end else begin
            case (funct3)
                F3_SB: begin
                    wdata = {4{data[7:0]}};
                    sel   = 4'b0001 << addr_lo;
                end
                F3_SH: begin
                    wdata      = {2{data[15:0]}};
                    sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
                    misaligned = addr_lo[0];
                end
                F3_SW: begin
                    sel        = 4'b1111;
                    misaligned = (addr_lo != 2'b00);
                end
                default: sel = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/core_mem_access.sv
// Memory stage: registers execute results, runs one data-bus transfer per load/store,
// traps misaligned accesses and bus timeouts, stalls upstream while the bus is busy.
module core_mem_access
    import core_mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [2:0]  i_funct3,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [1:0]  i_res_src,
    input  logic [29:0] i_pc_p4,
    input  logic [4:0]  i_rd,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic [31:0] o_alu_result,
    output logic [2:0]  o_funct3,
    output logic [1:0]  o_res_src,
    output logic [29:0] o_pc_p4,
    output logic [4:0]  o_rd,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output state_t      o_state,
    core_mem_access_if.master bus
);

    localparam int                CNT_W   = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam bit                TO_EN   = (BUS_TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(BUS_TIMEOUT - 1);

    state_t           state;
    trap_cause_t      cause_q;
    logic             req_q;
    logic             we_q;
    logic [29:0]      addr_q;
    logic [3:0]       sel_q;
    logic [31:0]      wdata_q;
    logic             load_q;
    logic             kill_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic        al_misaligned;
    logic        accept;
    logic        mem_op;

    core_mem_access_lsu_store_align u_align (
        .is_load    (i_mem_read),
        .funct3     (i_funct3),
        .addr_lo    (i_alu_result[1:0]),
        .data       (i_store_data),
        .sel        (al_sel),
        .wdata      (al_wdata),
        .misaligned (al_misaligned)
    );

    assign accept       = (state == ST_IDLE) && i_valid && !i_flush;
    assign mem_op       = i_mem_read || i_mem_write;
    assign o_stall      = (state == ST_WAIT_ACK);
    assign o_state      = state;
    assign o_trap_cause = cause_q;

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.sel   = sel_q;
    assign bus.wdata = wdata_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            cause_q      <= CAUSE_LOAD_MISALIGN;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            sel_q        <= '0;
            wdata_q      <= '0;
            load_q       <= 1'b0;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            o_valid      <= 1'b0;
            o_trap       <= 1'b0;
            o_data       <= '0;
            o_alu_result <= '0;
            o_funct3     <= '0;
            o_res_src    <= '0;
            o_pc_p4      <= '0;
            o_rd         <= '0;
        end else begin
            o_valid <= 1'b0;
            o_trap  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_alu_result <= i_alu_result;
                        o_funct3     <= i_funct3;
                        o_res_src    <= i_res_src;
                        o_pc_p4      <= i_pc_p4;
                        o_rd         <= i_rd;
                        o_data       <= '0;
                        if (!mem_op) begin
                            o_valid <= 1'b1;
                        end else if (al_misaligned) begin
                            o_trap  <= 1'b1;
                            cause_q <= i_mem_read ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= i_mem_write && !i_mem_read;
                            addr_q  <= i_alu_result[31:2];
                            sel_q   <= al_sel;
                            wdata_q <= al_wdata;
                            load_q  <= i_mem_read;
                            kill_q  <= 1'b0;
                            cnt_q   <= '0;
                            state   <= ST_WAIT_ACK;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack wins over a same-cycle timeout; a flush only hides the result.
                    if (bus.ack) begin
                        req_q   <= 1'b0;
                        o_data  <= load_q ? bus.rdata : 32'd0;
                        o_valid <= !(kill_q || i_flush);
                        state   <= ST_IDLE;
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        req_q   <= 1'b0;
                        o_trap  <= 1'b1;
                        cause_q <= CAUSE_BUS_TIMEOUT;
                        state   <= ST_IDLE;
                    end else begin
                        if (i_flush) kill_q <= 1'b1;
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_access.sv
// Directed bench for core_mem_access with a short bus timeout, checked by immediate assertions.
module tb_core_mem_access;
  import core_mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_mem_read, i_mem_write;
  logic [31:0] i_alu_result, i_store_data;
  logic [2:0]  i_funct3;
  logic [1:0]  i_res_src;
  logic [29:0] i_pc_p4;
  logic [4:0]  i_rd;
  logic        o_stall, o_valid, o_trap;
  logic [31:0] o_data, o_alu_result;
  logic [2:0]  o_funct3;
  logic [1:0]  o_res_src;
  logic [29:0] o_pc_p4;
  logic [4:0]  o_rd;
  logic [1:0]  o_trap_cause;
  state_t      o_state;
  int          total = 0;
  int          bad = 0;

  core_mem_access_if bus ();

  core_mem_access #(.BUS_TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_funct3(i_funct3),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_res_src(i_res_src),
    .i_pc_p4(i_pc_p4), .i_rd(i_rd), .o_stall(o_stall), .o_valid(o_valid),
    .o_data(o_data), .o_alu_result(o_alu_result), .o_funct3(o_funct3),
    .o_res_src(o_res_src), .o_pc_p4(o_pc_p4), .o_rd(o_rd), .o_trap(o_trap),
    .o_trap_cause(o_trap_cause), .o_state(o_state), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic send(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                      input logic rd_en, input logic wr_en, input logic [1:0] src,
                      input logic [29:0] pc, input logic [4:0] rd);
    i_valid = 1'b1; i_alu_result = alu; i_store_data = sd; i_funct3 = f3;
    i_mem_read = rd_en; i_mem_write = wr_en; i_res_src = src; i_pc_p4 = pc; i_rd = rd;
    tick();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] rdata);
    bus.ack = 1'b1; bus.rdata = rdata;
    tick();
    bus.ack = 1'b0; bus.rdata = 32'h0;
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_alu_result = '0; i_store_data = '0; i_funct3 = '0; i_res_src = '0; i_pc_p4 = '0; i_rd = '0;
    bus.ack = 1'b0; bus.rdata = '0;
    tick(); tick();
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_trap", 32'(o_trap), 32'd0);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_state", 32'(o_state), 32'(ST_IDLE));
    i_reset = 1'b0;
    tick();

    // sw 0x100, ack in third request cycle
    send(32'h100, 32'hDEADBEEF, 3'd2, 1'b0, 1'b1, 2'd0, 30'h0, 5'd0);
    check("sw_req", 32'(bus.req), 32'd1);
    check("sw_we", 32'(bus.we), 32'd1);
    check("sw_addr", 32'(bus.addr), 32'h40);
    check("sw_sel", 32'(bus.sel), 32'hF);
    check("sw_wdata", bus.wdata, 32'hDEADBEEF);
    check("sw_stall1", 32'(o_stall), 32'd1);
    tick();
    check("sw_stall2", 32'(o_stall), 32'd1);
    check("sw_wdata_hold", bus.wdata, 32'hDEADBEEF);
    tick();
    check("sw_stall3", 32'(o_stall), 32'd1);
    check("sw_valid_early", 32'(o_valid), 32'd0);
    ack_now(32'h55555555);
    check("sw_valid", 32'(o_valid), 32'd1);
    check("sw_req_drop", 32'(bus.req), 32'd0);
    check("sw_stall_low", 32'(o_stall), 32'd0);
    check("sw_data0", o_data, 32'd0);
    tick();
    check("sw_valid_pulse", 32'(o_valid), 32'd0);

    // sb 0x103
    send(32'h103, 32'h000000AB, 3'd0, 1'b0, 1'b1, 2'd0, 30'h0, 5'd0);
    check("sb_sel", 32'(bus.sel), 32'h8);
    check("sb_wdata", bus.wdata, 32'hABABABAB);
    ack_now(32'h0);
    check("sb_valid", 32'(o_valid), 32'd1);

    // sh 0x102 issued back-to-back in the cycle after the ack
    send(32'h102, 32'h00001234, 3'd1, 1'b0, 1'b1, 2'd0, 30'h0, 5'd0);
    check("sh_req", 32'(bus.req), 32'd1);
    check("sh_sel", 32'(bus.sel), 32'hC);
    check("sh_wdata", bus.wdata, 32'h12341234);
    ack_now(32'h0);
    check("sh_valid", 32'(o_valid), 32'd1);

    // lw 0x200 with pass-through fields
    send(32'h200, 32'h0, 3'd2, 1'b1, 1'b0, 2'd2, 30'h123, 5'd7);
    check("lw_we", 32'(bus.we), 32'd0);
    check("lw_sel", 32'(bus.sel), 32'hF);
    check("lw_addr", 32'(bus.addr), 32'h80);
    tick();
    ack_now(32'h80FF7F01);
    check("lw_valid", 32'(o_valid), 32'd1);
    check("lw_data", o_data, 32'h80FF7F01);
    check("lw_res_src", 32'(o_res_src), 32'd2);
    check("lw_rd", 32'(o_rd), 32'd7);
    check("lw_pc_p4", 32'(o_pc_p4), 32'h123);
    check("lw_alu", o_alu_result, 32'h200);

    // plain ALU op: latency 1, data zero
    send(32'h0000CAFE, 32'h0, 3'd0, 1'b0, 1'b0, 2'd0, 30'h10, 5'd3);
    check("alu_valid", 32'(o_valid), 32'd1);
    check("alu_data0", o_data, 32'd0);
    check("alu_result", o_alu_result, 32'h0000CAFE);
    check("alu_req", 32'(bus.req), 32'd0);

    // misaligned lh / sw
    send(32'h101, 32'h0, 3'd1, 1'b1, 1'b0, 2'd0, 30'h0, 5'd0);
    check("lh_mis_req", 32'(bus.req), 32'd0);
    check("lh_mis_trap", 32'(o_trap), 32'd1);
    check("lh_mis_cause", 32'(o_trap_cause), 32'd0);
    check("lh_mis_valid", 32'(o_valid), 32'd0);
    tick();
    check("lh_mis_pulse", 32'(o_trap), 32'd0);
    send(32'h102, 32'h0, 3'd2, 1'b0, 1'b1, 2'd0, 30'h0, 5'd0);
    check("sw_mis_trap", 32'(o_trap), 32'd1);
    check("sw_mis_cause", 32'(o_trap_cause), 32'd1);
    check("sw_mis_req", 32'(bus.req), 32'd0);
    tick();

    // timeout: request holds four cycles, then trap cause 2
    send(32'h300, 32'h1, 3'd2, 1'b0, 1'b1, 2'd0, 30'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req%0d", i), 32'(bus.req), 32'd1);
      check($sformatf("to_notrap%0d", i), 32'(o_trap), 32'd0);
      tick();
    end
    check("to_req_drop", 32'(bus.req), 32'd0);
    check("to_trap", 32'(o_trap), 32'd1);
    check("to_cause", 32'(o_trap_cause), 32'd2);
    check("to_stall", 32'(o_stall), 32'd0);
    check("to_valid", 32'(o_valid), 32'd0);
    check("to_state", 32'(o_state), 32'(ST_IDLE));
    tick();

    // flush during wait, then ALU op right after the ack
    send(32'h400, 32'h9, 3'd2, 1'b0, 1'b1, 2'd0, 30'h0, 5'd0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("fl_req_held", 32'(bus.req), 32'd1);
    tick();
    check("fl_req_held2", 32'(bus.req), 32'd1);
    ack_now(32'h0);
    check("fl_valid_supp", 32'(o_valid), 32'd0);
    check("fl_req_drop", 32'(bus.req), 32'd0);
    send(32'h00000077, 32'h0, 3'd0, 1'b0, 1'b0, 2'd1, 30'h0, 5'd1);
    check("fl_next_valid", 32'(o_valid), 32'd1);

    // flush and ack in the same cycle
    send(32'h500, 32'h0, 3'd2, 1'b1, 1'b0, 2'd0, 30'h0, 5'd0);
    i_flush = 1'b1;
    ack_now(32'h12345678);
    i_flush = 1'b0;
    check("flack_valid", 32'(o_valid), 32'd0);
    check("flack_stall", 32'(o_stall), 32'd0);

    // flush in IDLE discards the instruction
    i_flush = 1'b1;
    send(32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 2'd0, 30'h0, 5'd0);
    i_flush = 1'b0;
    check("flidle_valid", 32'(o_valid), 32'd0);
    check("flidle_req", 32'(bus.req), 32'd0);

    // stray ack while idle is ignored
    ack_now(32'hFFFFFFFF);
    check("stray_valid", 32'(o_valid), 32'd0);
    check("stray_state", 32'(o_state), 32'(ST_IDLE));

    // reserved store width: bus cycle with no byte enables, no trap
    send(32'h600, 32'h0, 3'd3, 1'b0, 1'b1, 2'd0, 30'h0, 5'd0);
    check("f3_sel", 32'(bus.sel), 32'h0);
    check("f3_trap", 32'(o_trap), 32'd0);
    check("f3_req", 32'(bus.req), 32'd1);
    ack_now(32'h0);

    // reset mid-transaction
    send(32'h700, 32'h0, 3'd2, 1'b1, 1'b0, 2'd0, 30'h0, 5'd0);
    check("rmid_req", 32'(bus.req), 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("rmid_req_drop", 32'(bus.req), 32'd0);
    check("rmid_stall", 32'(o_stall), 32'd0);
    ack_now(32'h1);
    check("rmid_valid", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
